// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts one arithmetic operation per request handshake, steps the
//   selected execution unit (combinational adder, multi-cycle multiplier or
//   multi-cycle divider) and returns one result per response handshake.
//
// Ports
//   clk, reset                   clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_op, req_a, req_b         0 ADD, 1 MUL, 2 DIV, 3 NAND; 32-bit operands
//   resp_valid/resp_ready        response handshake
//   resp_data, resp_hi, resp_err result low word / MUL high word / error flag
//   alu_a, alu_b                 latched operands shared by all units
//   add_cin, add_sum             adder carry-in (tied 0) and sum
//   mul_reset, mul_lo, mul_hi, mul_finished   multiplier control / product
//   div_reset, div_quot, div_finished         divider control / quotient
module alu_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] resp_hi,
  output logic        resp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  output logic        mul_reset,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi,
  input  logic        mul_finished,
  output logic        div_reset,
  input  logic [31:0] div_quot,
  input  logic        div_finished
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       hi_q, hi_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              unit_fin;

  assign unit_fin = (op_q == OP_MUL) ? mul_finished : div_finished;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    hi_d    = hi_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          err_d = 1'b0;
          // Divide-by-zero never starts the divider; it is answered directly.
          if (req_op == OP_ADD || req_op == OP_NAND ||
              (req_op == OP_DIV && req_b == 32'd0)) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_EXEC: begin
        hi_d  = 32'd0;
        err_d = (op_q == OP_DIV);
        case (op_q)
          OP_ADD:  data_d = add_sum;
          OP_NAND: data_d = ~(a_q & b_q);
          default: data_d = 32'd0;
        endcase
        state_d = S_RESP;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // The done flag may still be high from the previous operation during
        // the first WAIT cycle, so it is only trusted once the counter moved.
        if (cnt_q != '0 && unit_fin) begin
          data_d  = (op_q == OP_MUL) ? mul_lo : div_quot;
          hi_d    = (op_q == OP_MUL) ? mul_hi : 32'd0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'd0;
          hi_d    = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      data_q  <= 32'd0;
      hi_q    <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = data_q;
  assign resp_hi    = hi_q;
  assign resp_err   = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign add_cin    = 1'b0;
  // A unit is released from reset only while it is the one being waited on.
  assign mul_reset  = reset || !(state_q == S_WAIT && op_q == OP_MUL);
  assign div_reset  = reset || !(state_q == S_WAIT && op_q == OP_DIV);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_hi;
  logic        resp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        mul_reset;
  logic [31:0] mul_lo;
  logic [31:0] mul_hi;
  logic        mul_finished;
  logic        div_reset;
  logic [31:0] div_quot;
  logic        div_finished;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hi(resp_hi), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .add_cin(add_cin), .add_sum(add_sum),
    .mul_reset(mul_reset), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .mul_finished(mul_finished),
    .div_reset(div_reset), .div_quot(div_quot), .div_finished(div_finished)
  );

  // Execution unit models: adder is combinational, multiplier finishes after
  // 8 released cycles, divider after 5.
  logic [7:0] mcnt, dcnt;
  logic       mul_stuck, mul_never;
  logic       div_left, div_left_clr;

  assign add_sum = alu_a + alu_b + {31'd0, add_cin};
  assign {mul_hi, mul_lo} = {32'd0, alu_a} * {32'd0, alu_b};
  assign mul_finished = mul_stuck | (!mul_never & !mul_reset & (mcnt >= 8'd8));
  assign div_quot = (alu_b != 32'd0) ? alu_a / alu_b : 32'd0;
  assign div_finished = !div_reset & (dcnt >= 8'd5);

  always_ff @(posedge clk) begin
    if (mul_reset) mcnt <= 8'd0;
    else if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    if (div_reset) dcnt <= 8'd0;
    else if (dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
    if (div_left_clr) div_left <= 1'b0;
    else if (!div_reset) div_left <= 1'b1;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mr [0:255];
  logic dr [0:255];
  logic err_at1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and wait (bounded) for resp_valid.
  // lat counts cycles from the acceptance edge to the first resp_valid cycle.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int lat);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    mr[1] = mul_reset;
    dr[1] = div_reset;
    err_at1 = resp_err;
    while (!resp_valid && lat < 200) begin
      step();
      lat++;
      mr[lat] = mul_reset;
      dr[lat] = div_reset;
    end
    if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  int lat;
  int seen;
  logic [8:0] pat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0;
    resp_ready = 1'b0; mul_stuck = 1'b0; mul_never = 1'b0; div_left_clr = 1'b1;
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("rst_div_reset", 64'(div_reset), 64'd1);
    reset = 1'b0;
    div_left_clr = 1'b0;
    #1;
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_hi", 64'(resp_hi), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("add_cin", 64'(add_cin), 64'd0);

    // ADD
    send(2'd0, 32'd24, 32'd44, lat);
    check("add_lat", 64'(lat), 64'd2);
    check("add_data", 64'(resp_data), 64'd68);
    check("add_hi", 64'(resp_hi), 64'd0);
    check("add_err", 64'(resp_err), 64'd0);
    check("add_busy_ready", 64'(req_ready), 64'd0);
    ack();
    check("ack_valid_drop", 64'(resp_valid), 64'd0);
    check("ack_ready_back", 64'(req_ready), 64'd1);
    send(2'd0, 32'hFFFF_FFFF, 32'd2, lat);
    check("add_wrap", 64'(resp_data), 64'd1);
    ack();

    // MUL
    send(2'd1, 32'd24, 32'd44, lat);
    check("mul_lat", 64'(lat), 64'd11);
    check("mul_rst_issue", 64'(mr[1]), 64'd1);
    check("mul_rst_wait1", 64'(mr[2]), 64'd0);
    check("mul_rst_waitN", 64'(mr[10]), 64'd0);
    check("mul_rst_after", 64'(mr[11]), 64'd1);
    check("mul_div_held", 64'(dr[2]), 64'd1);
    check("mul_lo", 64'(resp_data), 64'd1056);
    check("mul_hi", 64'(resp_hi), 64'd0);
    ack();
    send(2'd1, 32'h0001_0000, 32'h0001_0000, lat);
    check("mul_big_lo", 64'(resp_data), 64'd0);
    check("mul_big_hi", 64'(resp_hi), 64'd1);
    ack();

    // NAND
    send(2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
    check("nand_lat", 64'(lat), 64'd2);
    check("nand_data", 64'(resp_data), 64'hF0F0_FFFF);
    check("nand_hi", 64'(resp_hi), 64'd0);
    ack();

    // DIV
    send(2'd2, 32'd100, 32'd7, lat);
    check("div_lat", 64'(lat), 64'd8);
    check("div_rst_wait", 64'(dr[2]), 64'd0);
    check("div_mul_held", 64'(mr[2]), 64'd1);
    check("div_data", 64'(resp_data), 64'd14);
    check("div_hi", 64'(resp_hi), 64'd0);
    check("div_err", 64'(resp_err), 64'd0);
    ack();
    div_left_clr = 1'b1;
    step();
    div_left_clr = 1'b0;
    send(2'd2, 32'd100, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd2);
    check("div0_err", 64'(resp_err), 64'd1);
    check("div0_data", 64'(resp_data), 64'd0);
    check("div0_unit_idle", 64'(div_left), 64'd0);
    ack();
    send(2'd0, 32'd1, 32'd1, lat);
    check("err_clear_on_accept", 64'(err_at1), 64'd0);
    check("err_clear_data", 64'(resp_data), 64'd2);
    ack();

    // Stale finished flag
    mul_stuck = 1'b1;
    send(2'd1, 32'd3, 32'd5, lat);
    check("stuck_lat", 64'(lat), 64'd4);
    check("stuck_data", 64'(resp_data), 64'd15);
    mul_stuck = 1'b0;
    ack();

    // Timeout
    mul_never = 1'b1;
    send(2'd1, 32'd2, 32'd3, lat);
    check("to_lat", 64'(lat), 64'd66);
    check("to_err", 64'(resp_err), 64'd1);
    check("to_data", 64'(resp_data), 64'd0);
    check("to_hi", 64'(resp_hi), 64'd0);
    check("to_rst_last_wait", 64'(mr[65]), 64'd0);
    check("to_rst_after", 64'(mr[66]), 64'd1);
    ack();
    mul_never = 1'b0;

    // Response held while consumer stalls
    send(2'd0, 32'd5, 32'd6, lat);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", 64'(resp_data), 64'd11);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    ack();

    // Reset during WAIT
    mul_never = 1'b1;
    req_op = 2'd1; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("midwait_rst_low", 64'(mul_reset), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_mul_reset", 64'(mul_reset), 64'd1);
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_err", 64'(resp_err), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (resp_valid) seen++;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    mul_never = 1'b0;

    // Back-to-back ADDs
    resp_ready = 1'b1;
    req_op = 2'd0; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
    pat = 9'd0;
    for (int i = 0; i < 9; i++) begin
      pat = {pat[7:0], req_ready};
      step();
    end
    req_valid = 1'b0;
    check("b2b_pattern", 64'(pat), 64'(9'b100100100));
    check("b2b_data", 64'(resp_data), 64'd3);
    step();
    step();
    resp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
